// File: rtl/alu_operand_sequencer_pkg.sv
// alu_pkg: shared ALU opcode/state types and datapath width for the operand sequencer.
package alu_pkg;
    localparam int ALU_W = 8;
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;
    typedef enum logic [1:0] {
        S_LOAD_A = 2'b00,
        S_LOAD_B = 2'b01,
        S_EXEC   = 2'b10,
        S_SHOW   = 2'b11
    } seq_state_e;
endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic             r_s1, r_s2, r_stable, r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    // a sample equal to the accepted level breaks the run of differing samples
    assign w_accept = (r_s2 != r_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_s1     <= i_btn;
            r_s2     <= r_s1;
            r_pulse  <= w_accept && r_s2;
            r_cnt    <= (r_s2 == r_stable || w_accept) ? '0 : r_cnt + 1'b1;
            r_stable <= w_accept ? r_s2 : r_stable;
        end
    end
    assign o_pulse = r_pulse;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: board switches/buttons to registered ALU operands, result capture for display.
// Define ALU_SEQ_CHAIN_EN to feed the shown result back as operand A (accumulator chaining).
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] i_sw,
    input  logic             i_btn_next,
    input  logic [1:0]       i_btn_op,
    input  logic [ALU_W-1:0] i_alu_result,
    output logic [ALU_W-1:0] o_alu_a,
    output logic [ALU_W-1:0] o_alu_b,
    output logic [1:0]       o_alu_ctrl,
    output logic [ALU_W-1:0] o_led,
    output logic [1:0]       o_state_led,
    output logic             o_result_valid
);
    seq_state_e       r_state, w_next;
    logic [ALU_W-1:0] r_sw_s1, r_sw_s2, r_a, r_b, r_result;
    logic [1:0]       r_op_s1, r_op_s2;
    alu_op_e          r_ctrl;
    logic             w_pulse;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn_next),
        .o_pulse (w_pulse)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_op_s1 <= '0;
            r_op_s2 <= '0;
        end else begin
            r_sw_s1 <= i_sw;
            r_sw_s2 <= r_sw_s1;
            r_op_s1 <= i_btn_op;
            r_op_s2 <= r_op_s1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOAD_A;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOAD_A: w_next = w_pulse ? S_LOAD_B : S_LOAD_A;
            S_LOAD_B: w_next = w_pulse ? S_EXEC : S_LOAD_B;
            S_EXEC:   w_next = S_SHOW;
`ifdef ALU_SEQ_CHAIN_EN
            S_SHOW:   w_next = w_pulse ? S_LOAD_B : S_SHOW;
`else
            S_SHOW:   w_next = w_pulse ? S_LOAD_A : S_SHOW;
`endif
            default:  w_next = S_LOAD_A;
        endcase
    end
    // operands are registered so the ALU inputs are stable a full cycle before EXEC samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= ALU_ADD;
            r_result <= '0;
        end else begin
            if (r_state == S_LOAD_A && w_pulse) r_a <= r_sw_s2;
            if (r_state == S_LOAD_B && w_pulse) begin
                r_b    <= r_sw_s2;
                r_ctrl <= alu_op_e'(r_op_s2);
            end
            if (r_state == S_EXEC) r_result <= i_alu_result;
`ifdef ALU_SEQ_CHAIN_EN
            if (r_state == S_SHOW && w_pulse) r_a <= r_result;
`endif
        end
    end
    always_comb begin
        o_led          = (r_state == S_SHOW) ? r_result : r_sw_s2;
        o_result_valid = (r_state == S_SHOW);
        o_state_led    = r_state;
    end
    assign o_alu_a    = r_a;
    assign o_alu_b    = r_b;
    assign o_alu_ctrl = r_ctrl;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed checks of the operand sequencer with a behavioural ALU on alu_result.
module tb_alu_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_next = 1'b0;
    logic [1:0] btn_op = 2'b00;
    logic [7:0] alu_result, alu_a, alu_b, led;
    logic [1:0] alu_ctrl, state_led;
    logic       result_valid;
    int         n_checks = 0;
    int         n_fail = 0;
    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sw           (sw),
        .i_btn_next     (btn_next),
        .i_btn_op       (btn_op),
        .i_alu_result   (alu_result),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_ctrl     (alu_ctrl),
        .o_led          (led),
        .o_state_led    (state_led),
        .o_result_valid (result_valid)
    );
    always #5 clk = ~clk;
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input logic [7:0] sw_v);
        sw = sw_v;
        wait_cyc(4);
        btn_next = 1'b1;
        wait_cyc(12);
        btn_next = 1'b0;
        wait_cyc(12);
    endtask
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(n);
        rst = 1'b0;
    endtask
    task automatic test_reset;
        do_reset(3);
        n_checks += 5;
        if (state_led !== 2'b00) begin n_fail++; $display("FAIL reset_state got %h exp 0", state_led); end
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h exp 00", led); end
        if ({alu_a, alu_b} !== 16'h0) begin n_fail++; $display("FAIL reset_ab got %h/%h exp 00/00", alu_a, alu_b); end
        if (alu_ctrl !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", alu_ctrl); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    endtask
    task automatic test_bounce;
        int bad = 0;
        sw = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            wait_cyc(3);
            btn_next = 1'b0;
            wait_cyc(1);
            if (state_led !== 2'b00) bad++;
        end
        wait_cyc(10);
        n_checks += 3;
        if (bad != 0) begin n_fail++; $display("FAIL bounce_during got %0d advances exp 0", bad); end
        if (state_led !== 2'b00) begin n_fail++; $display("FAIL bounce_state got %h exp 0", state_led); end
        if (led !== 8'h5A) begin n_fail++; $display("FAIL bounce_led_echo got %h exp 5a", led); end
    endtask
    task automatic test_held;
        sw = 8'h33;
        wait_cyc(4);
        btn_next = 1'b1;
        wait_cyc(100);
        n_checks += 2;
        if (state_led !== 2'b01) begin n_fail++; $display("FAIL held_state got %h exp 1", state_led); end
        if (alu_a !== 8'h33) begin n_fail++; $display("FAIL held_a got %h exp 33", alu_a); end
        btn_next = 1'b0;
        wait_cyc(20);
        n_checks++;
        if (state_led !== 2'b01) begin n_fail++; $display("FAIL release_state got %h exp 1", state_led); end
    endtask
    task automatic test_basic;
        do_reset(3);
        press(8'h15);
        n_checks += 2;
        if (state_led !== 2'b01) begin n_fail++; $display("FAIL basic_state_b got %h exp 1", state_led); end
        if (alu_a !== 8'h15) begin n_fail++; $display("FAIL basic_a got %h exp 15", alu_a); end
        btn_op = 2'b00;
        press(8'h0A);
        n_checks += 5;
        if (alu_b !== 8'h0A) begin n_fail++; $display("FAIL basic_b got %h exp 0a", alu_b); end
        if (alu_ctrl !== 2'b00) begin n_fail++; $display("FAIL basic_ctrl got %h exp 0", alu_ctrl); end
        if (state_led !== 2'b11) begin n_fail++; $display("FAIL basic_state_show got %h exp 3", state_led); end
        if (led !== 8'h1F) begin n_fail++; $display("FAIL basic_led got %h exp 1f", led); end
        if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", result_valid); end
        btn_op = 2'b11;
        sw = 8'hEE;
        wait_cyc(10);
        n_checks += 2;
        if (alu_ctrl !== 2'b00) begin n_fail++; $display("FAIL op_ignored got %h exp 0", alu_ctrl); end
        if (led !== 8'h1F) begin n_fail++; $display("FAIL show_hold got %h exp 1f", led); end
    endtask
    task automatic test_chain;
        press(8'h77);
`ifdef ALU_SEQ_CHAIN_EN
        n_checks += 2;
        if (state_led !== 2'b01) begin n_fail++; $display("FAIL chain_state got %h exp 1", state_led); end
        if (alu_a !== 8'h1F) begin n_fail++; $display("FAIL chain_a got %h exp 1f", alu_a); end
        btn_op = 2'b01;
        press(8'h03);
        n_checks += 3;
        if (alu_ctrl !== 2'b01) begin n_fail++; $display("FAIL chain_ctrl got %h exp 1", alu_ctrl); end
        if (led !== 8'h1C) begin n_fail++; $display("FAIL chain_led got %h exp 1c", led); end
        if (result_valid !== 1'b1) begin n_fail++; $display("FAIL chain_valid got %b exp 1", result_valid); end
`else
        n_checks += 3;
        if (state_led !== 2'b00) begin n_fail++; $display("FAIL nochain_state got %h exp 0", state_led); end
        if (alu_a !== 8'h15) begin n_fail++; $display("FAIL nochain_a got %h exp 15", alu_a); end
        if (led !== 8'h77) begin n_fail++; $display("FAIL nochain_led got %h exp 77", led); end
        btn_op = 2'b01;
        press(8'h20);
        press(8'h03);
        n_checks += 2;
        if (alu_ctrl !== 2'b01) begin n_fail++; $display("FAIL nochain_ctrl got %h exp 1", alu_ctrl); end
        if (led !== 8'h1D) begin n_fail++; $display("FAIL nochain_led2 got %h exp 1d", led); end
`endif
    endtask
    task automatic test_reset_in_show;
        btn_op = 2'b00;
        test_basic();
        sw = 8'h99;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (state_led !== 2'b00) begin n_fail++; $display("FAIL rstshow_state got %h exp 0", state_led); end
        if (led !== 8'h00) begin n_fail++; $display("FAIL rstshow_led got %h exp 00", led); end
        if ({alu_a, alu_b, alu_ctrl} !== 18'h0) begin n_fail++; $display("FAIL rstshow_alu got %h/%h/%h exp 0", alu_a, alu_b, alu_ctrl); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rstshow_valid got %b exp 0", result_valid); end
        rst = 1'b0;
    endtask
    initial begin
        test_reset();
        test_bounce();
        test_held();
        test_basic();
        test_chain();
        test_reset_in_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
